two_ch_readout: RTL and testbench

- Read-side controller for the dual-channel adaptive sampler.
- Waits until both sampler buffers report done, then walks the shared read_index across both buffers.
- Packs each stored 14-bit sample into a tagged 16-bit word and streams it out over a valid/ready handshake toward the host link.
- When the frame is drained, pulses rearm so the samplers restart capture.

---
 rtl/sampler_pkg.sv | 22 ++
 rtl/readout_word_pack.sv | 23 ++
 rtl/two_ch_readout.sv | 143 ++++++++++++++
 tb/tb_two_ch_readout.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sampler_pkg.sv
// Shared constants, stream-word field positions and readout FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sampler_pkg;

    localparam int IDX_W    = 10;
    localparam int DATA_W   = 14;
    localparam int WORD_W   = 16;
    localparam int CH_BIT   = 15;
    localparam int LAST_BIT = 14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WAIT,
        ST_SEND_A,
        ST_SEND_B,
        ST_FINISH,
        ST_REARM
    } rd_state_t;

endpackage

// File: rtl/readout_word_pack.sv
// Packs {channel, last, sample} into one tagged 16-bit stream word.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module readout_word_pack
    import sampler_pkg::*;
#(
    parameter int SAMPLE_W = sampler_pkg::DATA_W
) (
    input  logic                ch,
    input  logic                last,
    input  logic [SAMPLE_W-1:0] sample,
    output logic [WORD_W-1:0]   word
);

    // Place each field at its fixed bit position; unused bits stay zero.
    always_comb begin
        word                 = '0;
        word[SAMPLE_W-1:0]   = sample;
        word[LAST_BIT]       = last;
        word[CH_BIT]         = ch;
    end

endmodule

// File: rtl/two_ch_readout.sv
// Drains both sampler buffers as interleaved tagged words, then rearms the samplers.
// Latency: RD_LAT+1 cycles from address to first word; at most 2 words per RD_LAT+3 cycles.
// Backpressure: a presented word is held unchanged until out_ready accepts it.
module two_ch_readout #(
    parameter int IDX_W  = sampler_pkg::IDX_W,
    parameter int DATA_W = sampler_pkg::DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [IDX_W-1:0]  sample_target_A,
    input  logic [IDX_W-1:0]  sample_target_B,
    input  logic              done_A,
    input  logic              done_B,
    input  logic [DATA_W-1:0] data_out_A,
    input  logic [DATA_W-1:0] data_out_B,
    output logic [IDX_W-1:0]  read_index,
    output logic [15:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              rearm
);
    import sampler_pkg::*;

    rd_state_t          state, state_nxt;
    logic [IDX_W-1:0]   tgt_a, tgt_b, n_max, idx;
    logic [1:0]         lat_cnt;
    logic [DATA_W-1:0]  held_a, held_b;
    logic               rearm_sent;

    logic [IDX_W-1:0]   n_in;
    logic               start, has_a, has_b, is_final, advance_b;
    logic               word_ch, word_last;
    logic [DATA_W-1:0]  word_sample;
    logic [15:0]        packed_word;

    // Frame-level decode: start condition, per-channel presence, final-index test.
    always_comb begin
        n_in      = (sample_target_A > sample_target_B) ? sample_target_A : sample_target_B;
        start     = enable && done_A && done_B;
        has_a     = idx < tgt_a;
        has_b     = idx < tgt_b;
        // idx only ranges 0..n_max-1, so "idx+1 < n" is the same as "not the last index".
        is_final  = (idx == n_max - 1'b1);
        advance_b = !has_b || out_ready;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; word states advance only on a transfer or when the channel has no sample.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (start) state_nxt = (n_in == '0) ? ST_FINISH : ST_ADDR;
            ST_ADDR:   state_nxt = ST_WAIT;
            ST_WAIT:   if (lat_cnt == 2'd1) state_nxt = ST_SEND_A;
            ST_SEND_A: if (!has_a || out_ready) state_nxt = ST_SEND_B;
            ST_SEND_B: if (advance_b) state_nxt = is_final ? ST_FINISH : ST_ADDR;
            ST_FINISH: state_nxt = ST_REARM;
            ST_REARM:  if (!done_A && !done_B) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Frame datapath. read_index is loaded together with idx so it is already
    // presented during ADDR; the latency count therefore starts at ADDR.
    always_ff @(posedge clk) begin
        if (reset) begin
            tgt_a      <= '0;
            tgt_b      <= '0;
            n_max      <= '0;
            idx        <= '0;
            read_index <= '0;
            lat_cnt    <= '0;
            held_a     <= '0;
            held_b     <= '0;
            rearm_sent <= 1'b0;
        end else begin
            rearm_sent <= (state == ST_REARM);
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        tgt_a      <= sample_target_A;
                        tgt_b      <= sample_target_B;
                        n_max      <= n_in;
                        idx        <= '0;
                        read_index <= '0;
                    end
                end
                ST_ADDR: lat_cnt <= 2'(RD_LAT);
                ST_WAIT: begin
                    if (lat_cnt == 2'd1) begin
                        held_a <= data_out_A;
                        held_b <= data_out_B;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                ST_SEND_B: begin
                    if (advance_b && !is_final) begin
                        idx        <= idx + 1'b1;
                        read_index <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Word selection: the final word of the frame is B if B has a sample at the last index, else A.
    always_comb begin
        word_ch     = (state == ST_SEND_B);
        word_sample = word_ch ? held_b : held_a;
        word_last   = is_final && (word_ch ? has_b : !has_b);
    end

    readout_word_pack #(.SAMPLE_W(DATA_W)) u_pack (
        .ch     (word_ch),
        .last   (word_last),
        .sample (word_sample),
        .word   (packed_word)
    );

    // Outputs decoded from state; out_data is zero whenever no word is offered.
    always_comb begin
        out_valid  = ((state == ST_SEND_A) && has_a) || ((state == ST_SEND_B) && has_b);
        out_data   = out_valid ? packed_word : 16'h0000;
        busy       = (state != ST_IDLE);
        frame_done = (state == ST_FINISH);
        rearm      = (state == ST_REARM) && !rearm_sent;
    end

endmodule

// File: tb/tb_two_ch_readout.sv
module tb_two_ch_readout;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, done_a, done_b, out_ready;
    logic [9:0]  tgt_a, tgt_b;
    logic        en     [2];
    logic [9:0]  rd_idx [2];
    logic [13:0] dat_a  [2];
    logic [13:0] dat_b  [2];
    logic [15:0] odat   [2];
    logic        oval   [2];
    logic        busy   [2];
    logic        fdone  [2];
    logic        rearm  [2];

    two_ch_readout #(.RD_LAT(1)) u_lat1 (
        .clk(clk), .reset(reset), .enable(en[0]),
        .sample_target_A(tgt_a), .sample_target_B(tgt_b),
        .done_A(done_a), .done_B(done_b),
        .data_out_A(dat_a[0]), .data_out_B(dat_b[0]),
        .read_index(rd_idx[0]), .out_data(odat[0]), .out_valid(oval[0]),
        .out_ready(out_ready), .busy(busy[0]), .frame_done(fdone[0]), .rearm(rearm[0])
    );

    two_ch_readout #(.RD_LAT(3)) u_lat3 (
        .clk(clk), .reset(reset), .enable(en[1]),
        .sample_target_A(tgt_a), .sample_target_B(tgt_b),
        .done_A(done_a), .done_B(done_b),
        .data_out_A(dat_a[1]), .data_out_B(dat_b[1]),
        .read_index(rd_idx[1]), .out_data(odat[1]), .out_valid(oval[1]),
        .out_ready(out_ready), .busy(busy[1]), .frame_done(fdone[1]), .rearm(rearm[1])
    );

    // Sampler buffer models: data reflects the address presented RD_LAT cycles earlier.
    logic [13:0] mem_a [1024];
    logic [13:0] mem_b [1024];
    logic [9:0]  h1;
    logic [9:0]  h3 [3];
    always @(posedge clk) begin
        h1    <= rd_idx[0];
        h3[0] <= rd_idx[1];
        h3[1] <= h3[0];
        h3[2] <= h3[1];
    end
    always_comb begin
        dat_a[0] = mem_a[h1];
        dat_b[0] = mem_b[h1];
        dat_a[1] = mem_a[h3[2]];
        dat_b[1] = mem_b[h3[2]];
    end

    // Monitor of the selected instance: accepted words, pulses, handshake rule, addresses.
    int          mon_sel = 0;
    logic [15:0] got[$];
    logic [9:0]  ri_log[$];
    int          fd_cnt = 0, rm_cnt = 0, hs_err = 0;
    logic        stall = 1'b0, busy_d = 1'b0;
    logic [15:0] stall_dat = '0;
    always @(posedge clk) begin
        if (reset) begin
            stall  <= 1'b0;
            busy_d <= 1'b0;
        end else begin
            if (stall && (!oval[mon_sel] || odat[mon_sel] !== stall_dat)) hs_err <= hs_err + 1;
            stall     <= oval[mon_sel] && !out_ready;
            stall_dat <= odat[mon_sel];
            if (oval[mon_sel] && out_ready) got.push_back(odat[mon_sel]);
            if (fdone[mon_sel]) fd_cnt <= fd_cnt + 1;
            if (rearm[mon_sel]) rm_cnt <= rm_cnt + 1;
            if (busy[mon_sel] && (!busy_d || ri_log.size() == 0 || ri_log[$] !== rd_idx[mon_sel]))
                ri_log.push_back(rd_idx[mon_sel]);
            busy_d <= busy[mon_sel];
        end
    end

    int n_checks = 0, n_fail = 0;
    int frame_q0 = 0, frame_l0 = 0;

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks += 6;
        if (rd_idx[0] !== 10'd0) begin n_fail++; $display("FAIL reset_read_index got %h want 0", rd_idx[0]); end
        if (odat[0] !== 16'h0)   begin n_fail++; $display("FAIL reset_out_data got %h want 0", odat[0]); end
        if (oval[0] !== 1'b0)    begin n_fail++; $display("FAIL reset_out_valid got %b want 0", oval[0]); end
        if (busy[0] !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got %b want 0", busy[0]); end
        if (fdone[0] !== 1'b0)   begin n_fail++; $display("FAIL reset_frame_done got %b want 0", fdone[0]); end
        if (rearm[0] !== 1'b0)   begin n_fail++; $display("FAIL reset_rearm got %b want 0", rearm[0]); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // One full frame on instance k with a given ready duty; compares against a queue model.
    task automatic run_frame(input int k, input int ta, input int tb, input int pct, input bit fill);
        logic [15:0] exp[$];
        int n, cyc, r0, f0, h0;
        mon_sel = k;
        @(negedge clk);
        frame_q0 = got.size();
        frame_l0 = ri_log.size();
        r0 = rm_cnt; f0 = fd_cnt; h0 = hs_err;
        n = (ta > tb) ? ta : tb;
        for (int i = 0; i < n; i++) begin
            if (fill) begin
                mem_a[i] = 14'($urandom);
                mem_b[i] = 14'($urandom);
            end
            if (i < ta) exp.push_back({2'b00, mem_a[i]});
            if (i < tb) exp.push_back({2'b10, mem_b[i]});
        end
        if (exp.size() > 0) exp[exp.size()-1][14] = 1'b1;
        tgt_a = 10'(ta); tgt_b = 10'(tb);
        done_a = 1'b1; done_b = 1'b1; en[k] = 1'b1;
        cyc = 0;
        while (!busy[k] && cyc < 10) begin @(negedge clk); cyc++; end
        en[k] = 1'b0;
        tgt_a = 10'($urandom); tgt_b = 10'($urandom);
        cyc = 0;
        while (rm_cnt == r0 && cyc < 3000) begin
            out_ready = ($urandom_range(99) < pct);
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (rm_cnt == r0) begin n_fail++; $display("FAIL frame_timeout inst %0d got no rearm want rearm", k); end
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy[k] !== 1'b1) begin n_fail++; $display("FAIL rearm_hold busy got %b want 1", busy[k]); end
        done_a = 1'b0; done_b = 1'b0;
        cyc = 0;
        while (busy[k] && cyc < 5) begin @(negedge clk); cyc++; end
        n_checks += 4;
        if (busy[k] !== 1'b0) begin n_fail++; $display("FAIL idle_return busy got %b want 0", busy[k]); end
        if (fd_cnt - f0 != 1) begin n_fail++; $display("FAIL frame_done_count got %0d want 1", fd_cnt - f0); end
        if (rm_cnt - r0 != 1) begin n_fail++; $display("FAIL rearm_count got %0d want 1", rm_cnt - r0); end
        if (hs_err != h0)     begin n_fail++; $display("FAIL handshake_stability got %0d violations want 0", hs_err - h0); end
        n_checks++;
        if (got.size() - frame_q0 != exp.size()) begin
            n_fail++;
            $display("FAIL word_count got %0d want %0d", got.size() - frame_q0, exp.size());
        end
        for (int i = 0; i < exp.size() && frame_q0 + i < got.size(); i++) begin
            n_checks++;
            if (got[frame_q0+i] !== exp[i]) begin
                n_fail++;
                $display("FAIL word[%0d] got %h want %h", i, got[frame_q0+i], exp[i]);
            end
        end
    endtask

    task automatic test_equal();
        run_frame(0, 4, 4, 100, 1'b1);
    endtask

    task automatic test_unequal();
        run_frame(0, 5, 2, 100, 1'b1);
        n_checks++;
        if (ri_log.size() - frame_l0 != 5) begin
            n_fail++;
            $display("FAIL read_index_visits got %0d want 5", ri_log.size() - frame_l0);
        end
        for (int i = 0; i < 5 && frame_l0 + i < ri_log.size(); i++) begin
            n_checks++;
            if (ri_log[frame_l0+i] !== 10'(i)) begin
                n_fail++;
                $display("FAIL read_index_seq[%0d] got %0d want %0d", i, ri_log[frame_l0+i], i);
            end
        end
    endtask

    task automatic test_backpressure();
        run_frame(0, 3, 3, 30, 1'b1);
        run_frame(0, int'($urandom_range(1, 6)), int'($urandom_range(0, 6)), 50, 1'b1);
    endtask

    task automatic test_zero();
        int q0, r0, cyc;
        mon_sel = 0;
        @(negedge clk);
        q0 = got.size(); r0 = rm_cnt;
        tgt_a = 10'd0; tgt_b = 10'd0;
        done_a = 1'b1; done_b = 1'b1; en[0] = 1'b1;
        @(negedge clk);
        en[0] = 1'b0;
        n_checks += 2;
        if (fdone[0] !== 1'b1) begin n_fail++; $display("FAIL zero_frame_done got %b want 1", fdone[0]); end
        if (oval[0] !== 1'b0)  begin n_fail++; $display("FAIL zero_out_valid got %b want 0", oval[0]); end
        @(negedge clk);
        n_checks += 2;
        if (fdone[0] !== 1'b0) begin n_fail++; $display("FAIL zero_frame_done_width got %b want 0", fdone[0]); end
        if (rearm[0] !== 1'b1) begin n_fail++; $display("FAIL zero_rearm got %b want 1", rearm[0]); end
        repeat (4) @(negedge clk);
        n_checks += 2;
        if (rearm[0] !== 1'b0) begin n_fail++; $display("FAIL zero_rearm_width got %b want 0", rearm[0]); end
        if (busy[0] !== 1'b1)  begin n_fail++; $display("FAIL zero_rearm_hold got %b want 1", busy[0]); end
        done_a = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL zero_one_done_low busy got %b want 1", busy[0]); end
        done_b = 1'b0;
        cyc = 0;
        while (busy[0] && cyc < 5) begin @(negedge clk); cyc++; end
        n_checks += 3;
        if (busy[0] !== 1'b0)     begin n_fail++; $display("FAIL zero_idle busy got %b want 0", busy[0]); end
        if (got.size() != q0)     begin n_fail++; $display("FAIL zero_words got %0d want 0", got.size() - q0); end
        if (rm_cnt - r0 != 1)     begin n_fail++; $display("FAIL zero_rearm_count got %0d want 1", rm_cnt - r0); end
    endtask

    task automatic test_rdlat3();
        mem_a[0] = 14'h1234;
        mem_b[0] = 14'h0ABC;
        run_frame(1, 1, 1, 100, 1'b0);
        n_checks += 2;
        if (got.size() < frame_q0 + 2) begin
            n_fail++;
            $display("FAIL rdlat3_words got %0d want 2", got.size() - frame_q0);
        end else begin
            if (got[frame_q0] !== 16'h1234) begin n_fail++; $display("FAIL rdlat3_A0 got %h want 1234", got[frame_q0]); end
            if (got[frame_q0+1] !== 16'hCABC) begin n_fail++; $display("FAIL rdlat3_B0 got %h want cabc", got[frame_q0+1]); end
        end
        run_frame(1, 3, 3, 40, 1'b1);
    endtask

    task automatic test_reset_mid();
        int cyc, r0;
        mon_sel = 0;
        for (int i = 0; i < 4; i++) begin
            mem_a[i] = 14'($urandom);
            mem_b[i] = 14'($urandom);
        end
        tgt_a = 10'd4; tgt_b = 10'd4;
        done_a = 1'b1; done_b = 1'b1; en[0] = 1'b1; out_ready = 1'b1;
        cyc = 0;
        @(negedge clk);
        while (!(rd_idx[0] == 10'd2 && oval[0] && !odat[0][15]) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc >= 200) begin n_fail++; $display("FAIL reset_mid_reach got timeout want SEND_A at idx 2"); end
        r0 = rm_cnt;
        reset = 1'b1; en[0] = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        n_checks += 6;
        if (oval[0] !== 1'b0)    begin n_fail++; $display("FAIL reset_mid_out_valid got %b want 0", oval[0]); end
        if (odat[0] !== 16'h0)   begin n_fail++; $display("FAIL reset_mid_out_data got %h want 0", odat[0]); end
        if (busy[0] !== 1'b0)    begin n_fail++; $display("FAIL reset_mid_busy got %b want 0", busy[0]); end
        if (rd_idx[0] !== 10'd0) begin n_fail++; $display("FAIL reset_mid_read_index got %0d want 0", rd_idx[0]); end
        if (fdone[0] !== 1'b0)   begin n_fail++; $display("FAIL reset_mid_frame_done got %b want 0", fdone[0]); end
        if (rearm[0] !== 1'b0)   begin n_fail++; $display("FAIL reset_mid_rearm got %b want 0", rearm[0]); end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        n_checks += 2;
        if (rm_cnt != r0)     begin n_fail++; $display("FAIL reset_mid_no_rearm got %0d pulses want 0", rm_cnt - r0); end
        if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL reset_mid_stays_idle got %b want 0", busy[0]); end
        done_a = 1'b0; done_b = 1'b0;
        @(negedge clk);
        run_frame(0, 3, 2, 100, 1'b1);
    endtask

    initial begin
        reset = 1'b1; done_a = 1'b0; done_b = 1'b0; out_ready = 1'b0;
        tgt_a = '0; tgt_b = '0; en[0] = 1'b0; en[1] = 1'b0;
        test_reset();
        test_equal();
        test_unequal();
        test_backpressure();
        test_zero();
        test_rdlat3();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
